// File: rtl/axi_lite_mem_slave.sv
// axi_lite_mem_slave
// AXI4-Lite responder RAM used by the learn_simple_soc CPU's AXI master for
// instruction fetch and load/store. Word-addressed 32-bit storage with
// byte-strobed writes. Read and write channels run as independent FSMs with
// one outstanding transaction each.
//
// Parameters:
//   MEM_WORDS    depth in 32-bit words (power of 2)
//   INIT_FILE    name of the hex image the simulation/FPGA flow places in mem;
//                the array itself carries no reset or load logic
//   WAIT_CYCLES  extra response latency, only used with AXI_MEM_WAIT_EN
//
// Build option:
//   AXI_MEM_WAIT_EN  when defined, bvalid/rvalid arrive WAIT_CYCLES cycles
//                    later than the default single-cycle response.
//
// Ports:
//   clk_i, resetn_i              clock (rising edge), async active-low reset
//   aw*_i / awready_o            write address channel (awprot ignored)
//   w*_i  / wready_o             write data channel, wstrb bit i -> byte i
//   bvalid_o, bresp_o, bready_i  write response (OKAY / SLVERR)
//   ar*_i / arready_o            read address channel (arprot ignored)
//   rvalid_o, rdata_o, rresp_o,
//   rready_i                     read data channel (OKAY / SLVERR)
module axi_lite_mem_slave #(
  parameter int unsigned MEM_WORDS   = 4096,
  parameter string       INIT_FILE   = "firmware.hex",
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        resetn_i,
  input  logic        awvalid_i,
  output logic        awready_o,
  input  logic [31:0] awaddr_i,
  input  logic [2:0]  awprot_i,
  input  logic        wvalid_i,
  output logic        wready_o,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  wstrb_i,
  output logic        bvalid_o,
  input  logic        bready_i,
  output logic [1:0]  bresp_o,
  input  logic        arvalid_i,
  output logic        arready_o,
  input  logic [31:0] araddr_i,
  input  logic [2:0]  arprot_i,
  output logic        rvalid_o,
  input  logic        rready_i,
  output logic [31:0] rdata_o,
  output logic [1:0]  rresp_o
);

  localparam int unsigned IdxW       = $clog2(MEM_WORDS);
  localparam logic [1:0]  RespOkay   = 2'b00;
  localparam logic [1:0]  RespSlvErr = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wrState_e;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rdState_e;

  logic [31:0] mem [MEM_WORDS];

  // Any address bit above the word index means the access is past the end.
  function automatic logic outOfRange(input logic [31:0] addr);
    return (addr >> (IdxW + 2)) != 32'd0;
  endfunction

  function automatic logic [IdxW-1:0] wordIdx(input logic [31:0] addr);
    return addr[IdxW+1:2];
  endfunction

  wrState_e    wrState_q, wrState_d;
  logic        awGot_q, awGot_d, wGot_q, wGot_d;
  logic [31:0] awAddr_q, awAddr_d, wData_q, wData_d;
  logic [3:0]  wStrb_q, wStrb_d;
  logic        awready_q, awready_d, wready_q, wready_d;
  logic        bvalid_q, bvalid_d;
  logic [1:0]  bresp_q, bresp_d;
  logic        commitNow, memWrEn;

  rdState_e    rdState_q, rdState_d;
  logic [31:0] arAddr_q, arAddr_d;
  logic        arready_q, arready_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic        loadNow;

`ifdef AXI_MEM_WAIT_EN
  logic [7:0]  wrCnt_q, wrCnt_d, rdCnt_q, rdCnt_d;
`endif

  logic        unusedBits;
  assign unusedBits = ^{awprot_i, arprot_i, (INIT_FILE != ""), (WAIT_CYCLES != 0)};

  // Write channel: AW and W are captured independently, each ready dropping
  // once its beat is held. When the second beat lands the write commits and
  // the response is raised (optionally after the wait countdown).
  always_comb begin
    wrState_d = wrState_q;
    awGot_d   = awGot_q;
    wGot_d    = wGot_q;
    awAddr_d  = awAddr_q;
    wData_d   = wData_q;
    wStrb_d   = wStrb_q;
    awready_d = 1'b0;
    wready_d  = 1'b0;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    commitNow = 1'b0;
`ifdef AXI_MEM_WAIT_EN
    wrCnt_d   = wrCnt_q;
`endif
    case (wrState_q)
      W_IDLE: begin
        if (awvalid_i && awready_q) begin
          awGot_d  = 1'b1;
          awAddr_d = awaddr_i;
        end
        if (wvalid_i && wready_q) begin
          wGot_d  = 1'b1;
          wData_d = wdata_i;
          wStrb_d = wstrb_i;
        end
        if (awGot_d && wGot_d) begin
          awGot_d   = 1'b0;
          wGot_d    = 1'b0;
          wrState_d = W_RESP;
          commitNow = 1'b1;
`ifdef AXI_MEM_WAIT_EN
          if (WAIT_CYCLES != 0) begin
            wrState_d = W_WAIT;
            wrCnt_d   = 8'(WAIT_CYCLES);
            commitNow = 1'b0;
          end
`endif
        end else begin
          awready_d = !awGot_d;
          wready_d  = !wGot_d;
        end
      end
`ifdef AXI_MEM_WAIT_EN
      W_WAIT: begin
        wrCnt_d = wrCnt_q - 8'd1;
        if (wrCnt_q == 8'd1) begin
          wrState_d = W_RESP;
          commitNow = 1'b1;
        end
      end
`endif
      W_RESP: begin
        if (bready_i) begin
          bvalid_d  = 1'b0;
          wrState_d = W_IDLE;
        end
      end
      default: wrState_d = W_IDLE;
    endcase
    if (commitNow) begin
      bvalid_d = 1'b1;
      bresp_d  = outOfRange(awAddr_d) ? RespSlvErr : RespOkay;
    end
  end

  assign memWrEn = commitNow && !outOfRange(awAddr_d);

  // Read channel: one address at a time; data is sampled from the array on
  // the same edge a write may commit, so a colliding read sees the old word.
  always_comb begin
    rdState_d = rdState_q;
    arAddr_d  = arAddr_q;
    arready_d = 1'b0;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    loadNow   = 1'b0;
`ifdef AXI_MEM_WAIT_EN
    rdCnt_d   = rdCnt_q;
`endif
    case (rdState_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (arvalid_i && arready_q) begin
          arAddr_d  = araddr_i;
          arready_d = 1'b0;
          rdState_d = R_DATA;
          loadNow   = 1'b1;
`ifdef AXI_MEM_WAIT_EN
          if (WAIT_CYCLES != 0) begin
            rdState_d = R_WAIT;
            rdCnt_d   = 8'(WAIT_CYCLES);
            loadNow   = 1'b0;
          end
`endif
        end
      end
`ifdef AXI_MEM_WAIT_EN
      R_WAIT: begin
        rdCnt_d = rdCnt_q - 8'd1;
        if (rdCnt_q == 8'd1) begin
          rdState_d = R_DATA;
          loadNow   = 1'b1;
        end
      end
`endif
      R_DATA: begin
        if (rready_i) begin
          rvalid_d  = 1'b0;
          rdState_d = R_IDLE;
        end
      end
      default: rdState_d = R_IDLE;
    endcase
    if (loadNow) begin
      rvalid_d = 1'b1;
      if (outOfRange(arAddr_d)) begin
        rresp_d = RespSlvErr;
        rdata_d = 32'd0;
      end else begin
        rresp_d = RespOkay;
        rdata_d = mem[wordIdx(arAddr_d)];
      end
    end
  end

  // Control and output registers; reset clears every handshake output and
  // drops any transaction in flight.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      wrState_q <= W_IDLE;
      awGot_q   <= 1'b0;
      wGot_q    <= 1'b0;
      awAddr_q  <= 32'd0;
      wData_q   <= 32'd0;
      wStrb_q   <= 4'd0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      rdState_q <= R_IDLE;
      arAddr_q  <= 32'd0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= 32'd0;
      rresp_q   <= 2'b00;
`ifdef AXI_MEM_WAIT_EN
      wrCnt_q   <= 8'd0;
      rdCnt_q   <= 8'd0;
`endif
    end else begin
      wrState_q <= wrState_d;
      awGot_q   <= awGot_d;
      wGot_q    <= wGot_d;
      awAddr_q  <= awAddr_d;
      wData_q   <= wData_d;
      wStrb_q   <= wStrb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rdState_q <= rdState_d;
      arAddr_q  <= arAddr_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
`ifdef AXI_MEM_WAIT_EN
      wrCnt_q   <= wrCnt_d;
      rdCnt_q   <= rdCnt_d;
`endif
    end
  end

  // Storage array: never reset, byte lanes updated under wstrb.
  always_ff @(posedge clk_i) begin
    if (memWrEn) begin
      for (int b = 0; b < 4; b++) begin
        if (wStrb_d[b]) begin
          mem[wordIdx(awAddr_d)][8*b +: 8] <= wData_d[8*b +: 8];
        end
      end
    end
  end

  assign awready_o = awready_q;
  assign wready_o  = wready_q;
  assign bvalid_o  = bvalid_q;
  assign bresp_o   = bresp_q;
  assign arready_o = arready_q;
  assign rvalid_o  = rvalid_q;
  assign rdata_o   = rdata_q;
  assign rresp_o   = rresp_q;

endmodule

// File: tb/tb_axi_lite_mem_slave.sv
// tb_axi_lite_mem_slave
// Self-checking bench for axi_lite_mem_slave: directed corner cases plus a
// randomized read/write mix compared against a word-array reference model.
module tb_axi_lite_mem_slave;

  localparam int unsigned MemWords   = 1024;
  localparam int unsigned WaitCycles = 2;
  localparam int          NumInit    = 32;
`ifdef AXI_MEM_WAIT_EN
  localparam int ExpLat = 1 + WaitCycles;
`else
  localparam int ExpLat = 1;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b1;
  logic        arvalid = 1'b0, rready = 1'b1;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
  logic [3:0]  wstrb = '0;
  logic [2:0]  awprot = '0, arprot = '0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  logic [31:0] model [NumInit];
  int testsRun = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  axi_lite_mem_slave #(
    .MEM_WORDS(MemWords), .INIT_FILE(""), .WAIT_CYCLES(WaitCycles)
  ) dut (
    .clk_i(clk), .resetn_i(resetn),
    .awvalid_i(awvalid), .awready_o(awready), .awaddr_i(awaddr), .awprot_i(awprot),
    .wvalid_i(wvalid), .wready_o(wready), .wdata_i(wdata), .wstrb_i(wstrb),
    .bvalid_o(bvalid), .bready_i(bready), .bresp_o(bresp),
    .arvalid_i(arvalid), .arready_o(arready), .araddr_i(araddr), .arprot_i(arprot),
    .rvalid_o(rvalid), .rready_i(rready), .rdata_o(rdata), .rresp_o(rresp)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Reference byte-lane merge: each strobed byte takes the new data.
  function automatic logic [31:0] mergeBytes(input logic [31:0] old, input logic [31:0] data, input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (strb[b]) r = (r & ~(32'hFF << (8*b))) | (data & (32'hFF << (8*b)));
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present AW and W together and hold each until its own handshake.
  task automatic pushAwW(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    logic awHs, wHs, awDone, wDone;
    awDone = 1'b0;
    wDone  = 1'b0;
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1;
    for (int n = 0; n < 100 && !(awDone && wDone); n++) begin
      awHs = awvalid && awready;
      wHs  = wvalid && wready;
      tick();
      if (awHs) begin awDone = 1'b1; awvalid = 1'b0; end
      if (wHs)  begin wDone  = 1'b1; wvalid  = 1'b0; end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    checkOutput("aw_w_accepted", {30'd0, awDone, wDone}, 32'd3);
  endtask

  task automatic waitB(output logic [1:0] resp, output int lat);
    lat = 1;
    while (!bvalid && lat < 100) begin tick(); lat++; end
    checkOutput("bvalid_seen", {31'd0, bvalid}, 32'd1);
    resp = bresp;
    bready = 1'b1;
    tick();
  endtask

  task automatic axiWrite(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          output logic [1:0] resp, output int lat);
    pushAwW(addr, data, strb);
    waitB(resp, lat);
  endtask

  task automatic axiRead(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp, output int lat);
    logic hs, done;
    done = 1'b0;
    araddr = addr;
    arvalid = 1'b1;
    for (int n = 0; n < 100 && !done; n++) begin
      hs = arready;
      tick();
      if (hs) begin done = 1'b1; arvalid = 1'b0; end
    end
    arvalid = 1'b0;
    checkOutput("ar_accepted", {31'd0, done}, 32'd1);
    lat = 1;
    while (!rvalid && lat < 100) begin tick(); lat++; end
    checkOutput("rvalid_seen", {31'd0, rvalid}, 32'd1);
    data = rdata;
    resp = rresp;
    rready = 1'b1;
    tick();
  endtask

  // Random mix of in-range writes/reads and out-of-range accesses.
  task automatic applyStimulus(input int count);
    logic [31:0] addr, data, got;
    logic [3:0]  strb;
    logic [1:0]  resp;
    int          idx, lat, kind;
    for (int i = 0; i < count; i++) begin
      kind = int'($urandom_range(0, 9));
      idx  = int'($urandom_range(0, NumInit - 1));
      addr = 32'(idx * 4) + 32'($urandom_range(0, 3));
      if (kind < 4) begin
        data = $urandom;
        strb = (kind == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        axiWrite(addr, data, strb, resp, lat);
        model[idx] = mergeBytes(model[idx], data, strb);
        checkOutput("rnd_wr_bresp", {30'd0, resp}, 32'd0);
        checkOutput("rnd_wr_lat", lat, ExpLat);
      end else if (kind < 8) begin
        axiRead(addr, got, resp, lat);
        checkOutput("rnd_rd_data", got, model[idx]);
        checkOutput("rnd_rd_rresp", {30'd0, resp}, 32'd0);
        checkOutput("rnd_rd_lat", lat, ExpLat);
      end else begin
        addr = $urandom | 32'h8000_0000;
        if (kind == 8) begin
          axiWrite(addr, $urandom, 4'hF, resp, lat);
          checkOutput("rnd_oor_bresp", {30'd0, resp}, 32'd2);
        end else begin
          axiRead(addr, got, resp, lat);
          checkOutput("rnd_oor_rresp", {30'd0, resp}, 32'd2);
          checkOutput("rnd_oor_rdata", got, 32'd0);
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : mainSeq
    logic [31:0] got, wrData;
    logic [1:0]  resp;
    int          lat, bCount;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_awready", {31'd0, awready}, 32'd0);
    checkOutput("rst_wready", {31'd0, wready}, 32'd0);
    checkOutput("rst_arready", {31'd0, arready}, 32'd0);
    checkOutput("rst_valids", {30'd0, bvalid, rvalid}, 32'd0);
    checkOutput("rst_resp_data", {rdata[27:0], bresp, rresp}, 32'd0);
    resetn = 1'b1;
    #1;
    checkOutput("release_ready_low", {29'd0, awready, wready, arready}, 32'd0);
    tick();
    checkOutput("ready_after_clk", {29'd0, awready, wready, arready}, 32'd7);

    // Image load: word 0 holds the reset vector NOP, word 4 a known pattern.
    for (int i = 0; i < NumInit; i++) begin
      model[i] = (i == 0) ? 32'h0000_0013 : (i == 4) ? 32'h1122_3344 : $urandom;
      axiWrite(32'(i * 4), model[i], 4'hF, resp, lat);
      checkOutput("load_bresp", {30'd0, resp}, 32'd0);
    end
    checkOutput("load_wr_lat", lat, ExpLat);

    axiRead(32'h0, got, resp, lat);
    checkOutput("word0_data", got, 32'h0000_0013);
    checkOutput("word0_rresp", {30'd0, resp}, 32'd0);
    checkOutput("word0_lat", lat, ExpLat);

    axiWrite(32'h10, 32'hDEAD_BEEF, 4'b0101, resp, lat);
    model[4] = mergeBytes(model[4], 32'hDEAD_BEEF, 4'b0101);
    checkOutput("strb_bresp", {30'd0, resp}, 32'd0);
    axiRead(32'h10, got, resp, lat);
    checkOutput("strb_read", got, 32'h11AD_33EF);

    axiWrite(32'h10, 32'hFFFF_FFFF, 4'b0000, resp, lat);
    checkOutput("strb0_bresp", {30'd0, resp}, 32'd0);
    axiRead(32'h10, got, resp, lat);
    checkOutput("strb0_unchanged", got, model[4]);

    // W arrives three cycles ahead of AW.
    wdata = 32'hA5A5_0F0F; wstrb = 4'hF; wvalid = 1'b1;
    for (int n = 0; n < 100 && !wready; n++) tick();
    tick();
    wvalid = 1'b0;
    checkOutput("early_w_wready_drop", {30'd0, wready, awready}, 32'd1);
    repeat (3) begin
      checkOutput("early_w_no_bvalid", {31'd0, bvalid}, 32'd0);
      tick();
    end
    awaddr = 32'h14; awvalid = 1'b1;
    for (int n = 0; n < 100 && !awready; n++) tick();
    tick();
    awvalid = 1'b0;
    bCount = 0;
    for (int k = 0; k < 8; k++) begin
      if (bvalid) bCount++;
      tick();
    end
    checkOutput("early_w_one_bvalid", bCount, 1);
    model[5] = 32'hA5A5_0F0F;
    axiRead(32'h14, got, resp, lat);
    checkOutput("early_w_readback", got, model[5]);

    // Response back-pressure: second write must wait for the B handshake.
    bready = 1'b0;
    pushAwW(32'h18, 32'h0BAD_F00D, 4'hF);
    for (int n = 0; n < 100 && !bvalid; n++) tick();
    awaddr = 32'h1C; wdata = 32'h7777_8888; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      checkOutput("bp_hold", {29'd0, bvalid, awready, wready}, 32'd4);
      tick();
    end
    bready = 1'b1;
    tick();
    checkOutput("bp_released", {31'd0, bvalid}, 32'd0);
    pushAwW(32'h1C, 32'h7777_8888, 4'hF);
    waitB(resp, lat);
    model[6] = 32'h0BAD_F00D;
    model[7] = 32'h7777_8888;
    axiRead(32'h18, got, resp, lat);
    checkOutput("bp_first_write", got, model[6]);
    axiRead(32'h1C, got, resp, lat);
    checkOutput("bp_second_write", got, model[7]);

    // First address past the end of the array.
    axiWrite(MemWords * 4, 32'hCAFE_F00D, 4'hF, resp, lat);
    checkOutput("oor_bresp", {30'd0, resp}, 32'd2);
    axiRead(MemWords * 4, got, resp, lat);
    checkOutput("oor_rresp", {30'd0, resp}, 32'd2);
    checkOutput("oor_rdata", got, 32'd0);
    axiRead(32'h0, got, resp, lat);
    checkOutput("oor_word0_intact", got, model[0]);

    // Read and write to the same word committing on the same edge.
    repeat (3) tick();
    wrData = 32'h5555_AAAA;
    fork
      axiWrite(32'h20, wrData, 4'hF, resp, lat);
      axiRead(32'h20, got, resp, lat);
    join
    checkOutput("collide_old_data", got, model[8]);
    model[8] = wrData;
    axiRead(32'h20, got, resp, lat);
    checkOutput("collide_new_data", got, model[8]);

    applyStimulus(60);

    // Asynchronous reset while a read response is pending.
    rready = 1'b0;
    araddr = 32'h10; arvalid = 1'b1;
    for (int n = 0; n < 100 && !arready; n++) tick();
    tick();
    arvalid = 1'b0;
    for (int n = 0; n < 100 && !rvalid; n++) tick();
    checkOutput("pre_rst_rvalid", {31'd0, rvalid}, 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("async_rst_rvalid", {31'd0, rvalid}, 32'd0);
    checkOutput("async_rst_rdata", rdata, 32'd0);
    tick();
    tick();
    resetn = 1'b1;
    rready = 1'b1;
    checkOutput("rerelease_ready_low", {29'd0, awready, wready, arready}, 32'd0);
    tick();
    for (int i = 0; i < NumInit; i += 4) begin
      axiRead(32'(i * 4), got, resp, lat);
      checkOutput("mem_after_reset", got, model[i]);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
